// File: rtl/fetch_stage_pkg.sv
// Shared types for the instruction-fetch stage and its IF/ID bus.
package fetch_stage_pkg;

  localparam int unsigned PKG_XLEN = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    DISCARD
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]         instruction;
    logic [PKG_XLEN-1:0] pc;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic                valid;
  } if_id_bus_t;

endpackage

// File: rtl/fetch_stage_buffer.sv
// One-entry instruction holding register: load beats consume, flush beats both.
module fetch_buffer
  import fetch_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load,
  input  logic            consume,
  input  logic            flush,
  input  logic [31:0]     load_inst,
  input  logic [XLEN-1:0] load_pc,
  output logic            valid,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] pc
);

  // Entry register with valid flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      inst  <= NOP_INST;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      inst  <= load_inst;
      pc    <= load_pc;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding memory reads,
// buffers one instruction for the IF/ID register and handles redirects.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned     XLEN     = PKG_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            takebranch,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output if_id_bus_t      if_id_bus_out,
  output logic [31:0]     bubble_count
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic            redirect;
  logic            consume;
  logic            fire;
  logic            resp_take;
  logic            buf_valid;
  logic [31:0]     buf_inst;
  logic [XLEN-1:0] buf_pc;
  logic [XLEN-1:0] redirect_pc;

  assign redirect    = takebranch && !stall;
  assign consume     = !stall && !takebranch;
  assign redirect_pc = branch_target & ~XLEN'(3);
  assign resp_take   = (state == WAIT) && imem_resp_valid && !redirect;

  // Issue only when the entry is free (or draining this edge), so a response always has a slot
  always_comb begin
    imem_req_valid = !reset && (state == FETCH) && !redirect && (!buf_valid || consume);
    imem_req_addr  = pc;
    fire           = imem_req_valid && imem_req_ready;
  end

  fetch_buffer #(
    .XLEN(XLEN)
  ) u_buffer (
    .clock    (clock),
    .reset    (reset),
    .load     (resp_take),
    .consume  (consume),
    .flush    (redirect),
    .load_inst(imem_resp_data),
    .load_pc  (pc),
    .valid    (buf_valid),
    .inst     (buf_inst),
    .pc       (buf_pc)
  );

  // PC and request/response FSM; redirect outranks every event but reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      pc    <= RESET_PC & ~XLEN'(3);
    end else if (redirect) begin
      pc <= redirect_pc;
      unique case (state)
        FETCH:   state <= fire ? DISCARD : FETCH;
        WAIT:    state <= imem_resp_valid ? FETCH : DISCARD;
        DISCARD: state <= imem_resp_valid ? FETCH : DISCARD;
        default: state <= FETCH;
      endcase
    end else begin
      unique case (state)
        FETCH: if (fire) state <= WAIT;
        WAIT: begin
          if (imem_resp_valid) begin
            pc    <= pc + XLEN'(4);
            state <= FETCH;
          end
        end
        DISCARD: if (imem_resp_valid) state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

  // Saturating count of cycles where the decoder is free but nothing is buffered
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bubble_count <= '0;
    end else if (!stall && !buf_valid && (bubble_count != '1)) begin
      bubble_count <= bubble_count + 32'd1;
    end
  end

  // IF/ID bus presentation from the buffer entry
  always_comb begin
    if_id_bus_out.instruction = NOP_INST;
    if_id_bus_out.pc          = '0;
    if_id_bus_out.rs1         = '0;
    if_id_bus_out.rs2         = '0;
    if_id_bus_out.valid       = 1'b0;
    if (buf_valid) begin
      if_id_bus_out.instruction = buf_inst;
      if_id_bus_out.pc          = PKG_XLEN'(buf_pc);
      if_id_bus_out.rs1         = buf_inst[19:15];
      if_id_bus_out.rs2         = buf_inst[24:20];
      if_id_bus_out.valid       = 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        takebranch;
  logic [31:0] branch_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  if_id_bus_t  bus;
  logic [31:0] bubble_count;

  int          checks = 0;
  int          failures = 0;
  int          lat = 1;
  int          cnt = 0;
  logic        pend = 1'b0;
  logic [31:0] paddr = '0;

  fetch_stage #(
    .XLEN    (32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .takebranch     (takebranch),
    .branch_target  (branch_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .if_id_bus_out  (bus),
    .bubble_count   (bubble_count)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00A0_0113;
    return {a[11:0], 20'h00093};
  endfunction

  task automatic settle();
    #1;
  endtask

  // One clock: memory model accepts a handshake and returns data 'lat' cycles later
  task automatic cyc();
    logic        f;
    logic [31:0] a;
    #1;
    f = imem_req_valid && imem_req_ready;
    a = imem_req_addr;
    @(posedge clock);
    #1;
    imem_resp_valid = 1'b0;
    if (f) begin
      pend  = 1'b1;
      cnt   = lat;
      paddr = a;
    end
    if (pend) begin
      if (cnt <= 1) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem(paddr);
        pend = 1'b0;
      end else begin
        cnt--;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; takebranch = 1'b0; branch_target = '0;
    imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL rst_req_valid got=%0h exp=0", imem_req_valid); end
    checks++; if (bus.instruction !== 32'h0000_0013) begin failures++; $display("FAIL rst_inst got=%h exp=00000013", bus.instruction); end
    checks++; if ({bus.pc, bus.rs1, bus.rs2, bus.valid} !== '0) begin failures++; $display("FAIL rst_bus got=%h exp=0", {bus.pc, bus.rs1, bus.rs2, bus.valid}); end
    checks++; if (bubble_count !== 32'd0) begin failures++; $display("FAIL rst_bubble got=%0d exp=0", bubble_count); end
    reset = 1'b0;
    settle();
    checks++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin failures++; $display("FAIL rel_req got=%0h/%h exp=1/00000000", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_sequential();
    cyc();
    checks++; if ({imem_req_valid, bus.valid} !== 2'b00) begin failures++; $display("FAIL seq_wait0 got=%b exp=00", {imem_req_valid, bus.valid}); end
    cyc();
    checks++; if ({bus.valid, bus.pc, bus.instruction} !== {1'b1, 32'h0, 32'h0050_0093}) begin failures++; $display("FAIL seq_bus0 got=%0h/%h/%h exp=1/00000000/00500093", bus.valid, bus.pc, bus.instruction); end
    checks++; if ({bus.rs1, bus.rs2} !== {5'd0, 5'd5}) begin failures++; $display("FAIL seq_rs0 got=%0d/%0d exp=0/5", bus.rs1, bus.rs2); end
    checks++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h4}) begin failures++; $display("FAIL seq_req4 got=%0h/%h exp=1/00000004", imem_req_valid, imem_req_addr); end
    cyc();
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL seq_gap got=%0h exp=0", imem_req_valid); end
    cyc();
    checks++; if ({bus.valid, bus.pc, bus.instruction} !== {1'b1, 32'h4, 32'h00A0_0113}) begin failures++; $display("FAIL seq_bus4 got=%0h/%h/%h exp=1/00000004/00a00113", bus.valid, bus.pc, bus.instruction); end
    checks++; if ({bus.rs1, bus.rs2} !== {5'd0, 5'd10}) begin failures++; $display("FAIL seq_rs4 got=%0d/%0d exp=0/10", bus.rs1, bus.rs2); end
    checks++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h8}) begin failures++; $display("FAIL seq_req8 got=%0h/%h exp=1/00000008", imem_req_valid, imem_req_addr); end
    checks++; if (bubble_count !== 32'd3) begin failures++; $display("FAIL seq_bubble got=%0d exp=3", bubble_count); end
  endtask

  task automatic test_stall();
    cyc();
    cyc();
    stall = 1'b1;
    settle();
    for (int i = 0; i < 3; i++) begin
      checks++; if ({bus.valid, bus.pc, bus.instruction} !== {1'b1, 32'h8, 32'h0080_0093}) begin failures++; $display("FAIL stall_hold%0d got=%0h/%h/%h exp=1/00000008/00800093", i, bus.valid, bus.pc, bus.instruction); end
      checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL stall_noreq%0d got=%0h exp=0", i, imem_req_valid); end
      cyc();
    end
    checks++; if (bubble_count !== 32'd4) begin failures++; $display("FAIL stall_bubble got=%0d exp=4", bubble_count); end
    stall = 1'b0;
    settle();
    checks++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'hC}) begin failures++; $display("FAIL stall_next got=%0h/%h exp=1/0000000c", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_branch_wait();
    lat = 3;
    cyc();
    takebranch = 1'b1; branch_target = 32'h103;
    settle();
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL brw_redir_req got=%0h exp=0", imem_req_valid); end
    cyc();
    takebranch = 1'b0; branch_target = '0;
    settle();
    checks++; if ({imem_req_valid, bus.valid} !== 2'b00) begin failures++; $display("FAIL brw_disc1 got=%b exp=00", {imem_req_valid, bus.valid}); end
    cyc();
    checks++; if ({imem_req_valid, bus.valid} !== 2'b00) begin failures++; $display("FAIL brw_disc2 got=%b exp=00", {imem_req_valid, bus.valid}); end
    cyc();
    checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL brw_dropped got=%0h exp=0", bus.valid); end
    checks++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h100}) begin failures++; $display("FAIL brw_req got=%0h/%h exp=1/00000100", imem_req_valid, imem_req_addr); end
    lat = 1;
    cyc();
    checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL brw_pending got=%0h exp=0", bus.valid); end
    cyc();
    checks++; if ({bus.valid, bus.pc, bus.instruction} !== {1'b1, 32'h100, 32'h1000_0093}) begin failures++; $display("FAIL brw_bus got=%0h/%h/%h exp=1/00000100/10000093", bus.valid, bus.pc, bus.instruction); end
    checks++; if (imem_req_addr !== 32'h104) begin failures++; $display("FAIL brw_next got=%h exp=00000104", imem_req_addr); end
  endtask

  task automatic test_branch_resp();
    cyc();
    takebranch = 1'b1; branch_target = 32'h200;
    settle();
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL brr_redir_req got=%0h exp=0", imem_req_valid); end
    cyc();
    takebranch = 1'b0; branch_target = '0;
    settle();
    checks++; if ({imem_req_valid, imem_req_addr, bus.valid} !== {1'b1, 32'h200, 1'b0}) begin failures++; $display("FAIL brr_req got=%0h/%h/%0h exp=1/00000200/0", imem_req_valid, imem_req_addr, bus.valid); end
    cyc();
    cyc();
    checks++; if ({bus.valid, bus.pc, bus.instruction} !== {1'b1, 32'h200, 32'h2000_0093}) begin failures++; $display("FAIL brr_bus got=%0h/%h/%h exp=1/00000200/20000093", bus.valid, bus.pc, bus.instruction); end
  endtask

  task automatic test_branch_stall();
    stall = 1'b1; takebranch = 1'b1; branch_target = 32'h300;
    settle();
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL brs_req got=%0h exp=0", imem_req_valid); end
    cyc();
    checks++; if ({bus.valid, bus.pc} !== {1'b1, 32'h200}) begin failures++; $display("FAIL brs_hold got=%0h/%h exp=1/00000200", bus.valid, bus.pc); end
    cyc();
    stall = 1'b0; takebranch = 1'b0; branch_target = '0;
    settle();
    checks++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h204}) begin failures++; $display("FAIL brs_pc got=%0h/%h exp=1/00000204", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_reset_mid_wait();
    lat = 3;
    cyc();
    #1;
    reset = 1'b1;
    pend = 1'b0;
    imem_resp_valid = 1'b0;
    #1;
    checks++; if ({imem_req_valid, bus.valid, bus.instruction} !== {1'b0, 1'b0, 32'h0000_0013}) begin failures++; $display("FAIL mrst_out got=%0h/%0h/%h exp=0/0/00000013", imem_req_valid, bus.valid, bus.instruction); end
    checks++; if (bubble_count !== 32'd0) begin failures++; $display("FAIL mrst_bubble got=%0d exp=0", bubble_count); end
    @(posedge clock);
    #1;
    reset = 1'b0;
    lat = 1;
    settle();
    checks++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin failures++; $display("FAIL mrst_addr got=%0h/%h exp=1/00000000", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_ready_low();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      stall = (i == 2);
      settle();
      checks++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin failures++; $display("FAIL rdy_hold%0d got=%0h/%h exp=1/00000000", i, imem_req_valid, imem_req_addr); end
      cyc();
    end
    stall = 1'b0;
    settle();
    checks++; if (bubble_count !== 32'd3) begin failures++; $display("FAIL rdy_bubble got=%0d exp=3", bubble_count); end
    imem_req_ready = 1'b1;
    cyc();
    cyc();
    checks++; if ({bus.valid, bus.pc, bus.instruction} !== {1'b1, 32'h0, 32'h0050_0093}) begin failures++; $display("FAIL rdy_bus got=%0h/%h/%h exp=1/00000000/00500093", bus.valid, bus.pc, bus.instruction); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch_wait();
    test_branch_resp();
    test_branch_stall();
    test_reset_mid_wait();
    test_ready_low();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
